avalon_pipeline_slave: RTL and testbench
========================================

Name: avalon_pipeline_slave

Overview:
- Avalon-MM pipelined slave (responder): the target end of the bus monitored by the team's Avalon assertion checkers.
- Internal word-addressed memory, byte-enabled writes, reads returned with a fixed READLATENCY and readdatavalid.
- Optional pseudo-random waitrequest stalls exercise master back-pressure handling.
- Sits in the testbench as the DUT-facing slave model paired with the assertion monitor.

Parameters:
- NBDATABYTES, 2, data bus width in bytes; data width DW = 8*NBDATABYTES.
- NBADDRBITS, 8, word address width; memory depth 2**NBADDRBITS words.
- READLATENCY, 2, cycles from read acceptance to readdatavalid; legal range 1..8.
- STALLEN, 0, 1 enables LFSR-driven waitrequest stalls; 0 means waitrequest only during reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- address  in  NBADDRBITS  word address.
- byteenable  in  NBDATABYTES  write byte lanes; ignored for reads.
- writedata  in  DW  write data.
- read  in  1  read request.
- write  in  1  write request.
- waitrequest  out  1  slave stall; a request is held by the master while high.
- readdata  out  DW  read data, valid only with readdatavalid.
- readdatavalid  out  1  one-cycle pulse per accepted read.
- protocol_error  out  1  sticky flag: read and write seen high in the same cycle.
- read_count  out  16  accepted reads, wraps at 0xFFFF to 0.
- write_count  out  16  accepted writes, wraps at 0xFFFF to 0.

Behaviour:
Reset values (rst high at a clk edge):
- waitrequest=1, readdatavalid=0, readdata=0, protocol_error=0, read_count=0, write_count=0.
- Delay line cleared, so in-flight reads are dropped and no readdatavalid follows reset.
- LFSR = 8'h01. Memory contents are not reset.

Stall generation:
- stall_q is registered and drives waitrequest directly.
- LFSR is 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, and advances every non-reset cycle.
- Next stall_q = STALLEN ? (lfsr[1:0]==2'b00) : 0. With STALLEN=0, waitrequest falls on the first cycle after reset.

Acceptance:
- A request is accepted at a clk edge where (read XOR write) and !waitrequest.
- Requests while waitrequest=1 are not accepted and have no side effects; the master holds them.

Write:
- On acceptance, mem[address] byte lane i is updated only where byteenable[i]=1.
- Single cycle, no response.
- write_count increments.

Read:
- On acceptance, mem[address] is sampled into stage 0 of a READLATENCY-deep valid+data delay line; read_count increments.
- Reads return the full word; byteenable is ignored.
- readdatavalid/readdata come from the last stage, exactly READLATENCY cycles after the accepting edge.
- Back-to-back reads give back-to-back readdatavalid pulses, in order.
- readdata is 0 whenever readdatavalid=0.

Hazard:
- A write accepted at edge N followed by a read of the same address accepted at edge N+1 returns the new data.
- A same-edge read+write cannot occur; see Error.

Error:
- read&write both high at a clk edge sets protocol_error (sticky until rst).
- Neither operation is performed and neither counter changes.
- The delay line keeps advancing.

Simultaneous events:
- Reset dominates everything.
- A stall asserted at the same edge that accepts a request does not cancel that acceptance, because acceptance uses the pre-edge waitrequest.

Test Plan:
1. STALLEN=0, reset 3 cycles then release -> waitrequest=1 during reset, 0 on the first post-reset cycle; all outputs at reset values.
2. Write addr 0x10 data 0xBEEF byteenable 2'b11, then write addr 0x10 data 0x1234 byteenable 2'b01, then read 0x10 -> readdatavalid exactly 2 cycles after read acceptance with readdata=0xBE34; read_count=1, write_count=2.
3. Four back-to-back reads of addresses 0x00..0x03 preloaded with 0xA0..0xA3 -> four consecutive readdatavalid pulses starting 2 cycles after the first acceptance, data 0xA0,0xA1,0xA2,0xA3 in order.
4. STALLEN=1, master holds read 0x05 (preloaded 0x5555) until waitrequest=0 -> exactly one acceptance, one readdatavalid pulse 2 cycles later with 0x5555; read_count increments by 1; assertion monitor reports no failure.
5. read=1 and write=1 for one cycle at addr 0x20 (preloaded 0x0F0F, writedata 0xFFFF) -> protocol_error=1 and stays 1; counters unchanged; subsequent read of 0x20 returns 0x0F0F.
6. Read accepted, rst asserted 1 cycle later -> no readdatavalid ever appears for that read; counters 0 after reset.

Source files
------------

// File: rtl/avalon_pipeline_slave.sv
`default_nettype none
// ============================================================================
//  Module   : avalon_pipeline_slave
//  Purpose  : Avalon-MM pipelined responder with an internal word-addressed
//             memory, byte-enabled writes, fixed-latency reads returned with
//             readdatavalid, and optional pseudo-random waitrequest stalls.
//  Ports    : clk, rst            - clock (rising edge), sync active-high reset
//             address             - word address (NBADDRBITS)
//             byteenable          - write byte lanes (NBDATABYTES)
//             writedata/readdata  - data buses (8*NBDATABYTES)
//             read/write          - request strobes
//             waitrequest         - registered stall, master holds while high
//             readdatavalid       - one-cycle pulse per accepted read
//             protocol_error      - sticky, read and write high together
//             read_count/write_count - 16-bit wrapping acceptance counters
//  Revision : 1.0 - initial release
// ============================================================================
module avalon_pipeline_slave #(
    parameter int NBDATABYTES = 2,
    parameter int NBADDRBITS  = 8,
    parameter int READLATENCY = 2,   // legal range 1..8
    parameter int STALLEN     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NBADDRBITS-1:0]    address,
    input  logic [NBDATABYTES-1:0]   byteenable,
    input  logic [8*NBDATABYTES-1:0] writedata,
    input  logic                     read,
    input  logic                     write,
    output logic                     waitrequest,
    output logic [8*NBDATABYTES-1:0] readdata,
    output logic                     readdatavalid,
    output logic                     protocol_error,
    output logic [15:0]              read_count,
    output logic [15:0]              write_count
);

    localparam int c_DW    = 8 * NBDATABYTES;
    localparam int c_DEPTH = 2 ** NBADDRBITS;

    logic [c_DW-1:0]        r_mem [c_DEPTH];
    logic [7:0]             r_lfsr;
    logic                   r_stall;
    logic                   r_perr;
    logic [15:0]            r_rd_cnt;
    logic [15:0]            r_wr_cnt;
    logic [READLATENCY-1:0] r_vld;
    logic [c_DW-1:0]        r_dat [READLATENCY];

    logic                   w_rd_acc;
    logic                   w_wr_acc;
    logic                   w_lfsr_fb;

    // Acceptance is judged against the pre-edge waitrequest, so a stall
    // raised at the same edge never cancels the request it coincides with.
    assign w_rd_acc  = read  & ~write & ~r_stall;
    assign w_wr_acc  = write & ~read  & ~r_stall;

    // Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    // Stall generator and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr   <= 8'h01;
            r_stall  <= 1'b1;
            r_perr   <= 1'b0;
            r_rd_cnt <= 16'd0;
            r_wr_cnt <= 16'd0;
        end else begin
            r_lfsr   <= {r_lfsr[6:0], w_lfsr_fb};
            r_stall  <= (STALLEN != 0) ? (r_lfsr[1:0] == 2'b00) : 1'b0;
            if (read && write) begin
                r_perr <= 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_cnt <= r_rd_cnt + 16'd1;
            end
            if (w_wr_acc) begin
                r_wr_cnt <= r_wr_cnt + 16'd1;
            end
        end
    end

    // Memory contents survive reset; only accepted writes touch them.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_acc) begin
            for (int i = 0; i < NBDATABYTES; i++) begin
                if (byteenable[i]) begin
                    r_mem[address][i*8 +: 8] <= writedata[i*8 +: 8];
                end
            end
        end
    end

    // Read delay line. Data is forced to zero in empty slots so that the
    // output bus is quiet whenever readdatavalid is low. A write accepted on
    // the previous edge is already in r_mem, so read-after-write is coherent.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < READLATENCY; i++) begin
                r_dat[i] <= '0;
            end
        end else begin
            r_vld[0] <= w_rd_acc;
            r_dat[0] <= w_rd_acc ? r_mem[address] : '0;
            for (int i = 1; i < READLATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_dat[i] <= r_dat[i-1];
            end
        end
    end

    assign waitrequest    = r_stall;
    assign readdatavalid  = r_vld[READLATENCY-1];
    assign readdata       = r_dat[READLATENCY-1];
    assign protocol_error = r_perr;
    assign read_count     = r_rd_cnt;
    assign write_count    = r_wr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_avalon_pipeline_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_avalon_pipeline_slave
//  Purpose  : Directed self-checking bench. Instance dut runs with stalls
//             disabled, instance dut_s with LFSR stalls enabled.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_avalon_pipeline_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [7:0]  a_addr = '0;
    logic [1:0]  a_be   = '0;
    logic [15:0] a_wd   = '0;
    logic        a_rd   = 1'b0;
    logic        a_wr   = 1'b0;
    logic        a_wait, a_rvalid, a_perr;
    logic [15:0] a_rdata, a_rcnt, a_wcnt;

    logic [7:0]  s_addr = '0;
    logic [1:0]  s_be   = '0;
    logic [15:0] s_wd   = '0;
    logic        s_rd   = 1'b0;
    logic        s_wr   = 1'b0;
    logic        s_wait, s_rvalid, s_perr;
    logic [15:0] s_rdata, s_rcnt, s_wcnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    avalon_pipeline_slave #(
        .NBDATABYTES(2), .NBADDRBITS(8), .READLATENCY(2), .STALLEN(0)
    ) dut (
        .clk(clk), .rst(rst), .address(a_addr), .byteenable(a_be),
        .writedata(a_wd), .read(a_rd), .write(a_wr), .waitrequest(a_wait),
        .readdata(a_rdata), .readdatavalid(a_rvalid), .protocol_error(a_perr),
        .read_count(a_rcnt), .write_count(a_wcnt)
    );

    avalon_pipeline_slave #(
        .NBDATABYTES(2), .NBADDRBITS(8), .READLATENCY(2), .STALLEN(1)
    ) dut_s (
        .clk(clk), .rst(rst), .address(s_addr), .byteenable(s_be),
        .writedata(s_wd), .read(s_rd), .write(s_wr), .waitrequest(s_wait),
        .readdata(s_rdata), .readdatavalid(s_rvalid), .protocol_error(s_perr),
        .read_count(s_rcnt), .write_count(s_wcnt)
    );

    // Issue one request on dut and hold it until accepted. Called and
    // returning at posedge+1, the request deasserted after the accepting edge.
    task automatic a_op(input logic rd, input logic wr, input logic [7:0] addr,
                        input logic [15:0] wd, input logic [1:0] be);
        logic w;
        bit   done = 0;
        a_addr = addr; a_wd = wd; a_be = be; a_rd = rd; a_wr = wr;
        for (int n = 0; n < 20 && !done; n++) begin
            w = a_wait;
            @(posedge clk); #1;
            if (!w) done = 1;
        end
        a_rd = 1'b0; a_wr = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL a_op_accept: got not accepted, expected accepted within 20 cycles");
        end
    endtask

    task automatic s_op(input logic rd, input logic wr, input logic [7:0] addr,
                        input logic [15:0] wd, input logic [1:0] be,
                        output int cycles, output int pulses);
        logic w;
        bit   done = 0;
        cycles = 0; pulses = 0;
        s_addr = addr; s_wd = wd; s_be = be; s_rd = rd; s_wr = wr;
        for (int n = 0; n < 40 && !done; n++) begin
            w = s_wait;
            @(posedge clk); #1;
            cycles++;
            if (!w) done = 1;
            else if (s_rvalid) pulses++;
        end
        s_rd = 1'b0; s_wr = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL s_op_accept: got not accepted, expected accepted within 40 cycles");
        end
    endtask

    task automatic test_reset;
        logic exp_s [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({a_wait, a_rvalid, a_rdata, a_perr, a_rcnt, a_wcnt} !== {1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0}) begin
                n_fail++;
                $display("FAIL reset_outputs: got wait=%b rv=%b rd=%h perr=%b rc=%h wc=%h, expected 1 0 0000 0 0000 0000",
                         a_wait, a_rvalid, a_rdata, a_perr, a_rcnt, a_wcnt);
            end
            n_checks++;
            if (s_wait !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_wait_s: got %b, expected 1", s_wait);
            end
        end
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (a_wait !== 1'b0) begin
                n_fail++;
                $display("FAIL wait_nostall[%0d]: got %b, expected 0", k, a_wait);
            end
            n_checks++;
            if (s_wait !== exp_s[k]) begin
                n_fail++;
                $display("FAIL lfsr_stall[%0d]: got %b, expected %b", k, s_wait, exp_s[k]);
            end
        end
    endtask

    task automatic test_byteenable_hazard;
        a_op(1'b0, 1'b1, 8'h10, 16'hBEEF, 2'b11);
        a_op(1'b0, 1'b1, 8'h10, 16'h1234, 2'b01);
        a_op(1'b1, 1'b0, 8'h10, 16'h0000, 2'b00);   // read right after write
        n_checks++;
        if (a_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_early: got rvalid=%b, expected 0", a_rvalid);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({a_rvalid, a_rdata} !== {1'b1, 16'hBE34}) begin
            n_fail++;
            $display("FAIL rd_be_data: got rv=%b data=%h, expected 1 BE34", a_rvalid, a_rdata);
        end
        n_checks++;
        if ({a_rcnt, a_wcnt} !== {16'd1, 16'd2}) begin
            n_fail++;
            $display("FAIL rd_be_counts: got rc=%0d wc=%0d, expected 1 2", a_rcnt, a_wcnt);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({a_rvalid, a_rdata} !== {1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL rd_pulse_end: got rv=%b data=%h, expected 0 0000", a_rvalid, a_rdata);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) a_op(1'b0, 1'b1, 8'(i), 16'(16'hA0 + i), 2'b11);
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin a_addr = 8'(k); a_rd = 1'b1; end
            else a_rd = 1'b0;
            @(posedge clk); #1;
            n_checks++;
            if (k >= 1 && k <= 4) begin
                if ({a_rvalid, a_rdata} !== {1'b1, 16'(16'hA0 + k - 1)}) begin
                    n_fail++;
                    $display("FAIL b2b[%0d]: got rv=%b data=%h, expected 1 %h", k, a_rvalid, a_rdata, 16'(16'hA0 + k - 1));
                end
            end else if ({a_rvalid, a_rdata} !== {1'b0, 16'h0000}) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got rv=%b data=%h, expected 0 0000", k, a_rvalid, a_rdata);
            end
        end
        a_rd = 1'b0;
    endtask

    task automatic test_protocol_error;
        logic [15:0] rc0, wc0;
        a_op(1'b0, 1'b1, 8'h20, 16'h0F0F, 2'b11);
        rc0 = a_rcnt; wc0 = a_wcnt;
        n_checks++;
        if (a_perr !== 1'b0) begin
            n_fail++;
            $display("FAIL perr_before: got %b, expected 0", a_perr);
        end
        a_addr = 8'h20; a_wd = 16'hFFFF; a_be = 2'b11; a_rd = 1'b1; a_wr = 1'b1;
        @(posedge clk); #1;
        a_rd = 1'b0; a_wr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({a_perr, a_rvalid, a_rcnt, a_wcnt} !== {1'b1, 1'b0, rc0, wc0}) begin
                n_fail++;
                $display("FAIL perr_sticky[%0d]: got perr=%b rv=%b rc=%0d wc=%0d, expected 1 0 %0d %0d",
                         k, a_perr, a_rvalid, a_rcnt, a_wcnt, rc0, wc0);
            end
            @(posedge clk); #1;
        end
        a_op(1'b1, 1'b0, 8'h20, 16'h0000, 2'b00);
        @(posedge clk); #1;
        n_checks++;
        if ({a_rvalid, a_rdata, a_perr} !== {1'b1, 16'h0F0F, 1'b1}) begin
            n_fail++;
            $display("FAIL perr_mem_kept: got rv=%b data=%h perr=%b, expected 1 0F0F 1", a_rvalid, a_rdata, a_perr);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall_read;
        int cyc, pul, guard;
        logic [15:0] rc0;
        s_op(1'b0, 1'b1, 8'h05, 16'h5555, 2'b11, cyc, pul);
        // Start the read while a stall is active so the hold path is exercised.
        guard = 0;
        while (s_wait !== 1'b1 && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        n_checks++;
        if (s_wait !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_seen: got wait=%b, expected 1 within 40 cycles", s_wait);
        end
        rc0 = s_rcnt;
        s_op(1'b1, 1'b0, 8'h05, 16'h0000, 2'b00, cyc, pul);
        n_checks++;
        if (cyc < 2 || pul != 0) begin
            n_fail++;
            $display("FAIL stall_hold: got cycles=%0d pulses=%0d, expected cycles>=2 pulses=0", cyc, pul);
        end
        n_checks++;
        if ({s_rvalid, s_rcnt} !== {1'b0, 16'(rc0 + 16'd1)}) begin
            n_fail++;
            $display("FAIL stall_accept: got rv=%b rc=%0d, expected 0 %0d", s_rvalid, s_rcnt, rc0 + 16'd1);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({s_rvalid, s_rdata} !== {1'b1, 16'h5555}) begin
            n_fail++;
            $display("FAIL stall_rdata: got rv=%b data=%h, expected 1 5555", s_rvalid, s_rdata);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({s_rvalid, s_rcnt} !== {1'b0, 16'(rc0 + 16'd1)}) begin
                n_fail++;
                $display("FAIL stall_single[%0d]: got rv=%b rc=%0d, expected 0 %0d", k, s_rvalid, s_rcnt, rc0 + 16'd1);
            end
        end
    endtask

    task automatic test_reset_inflight;
        a_op(1'b1, 1'b0, 8'h10, 16'h0000, 2'b00);
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if ({a_rvalid, a_rdata, a_rcnt, a_wcnt, a_perr} !== {1'b0, 16'h0, 16'h0, 16'h0, 1'b0}) begin
                n_fail++;
                $display("FAIL rst_inflight[%0d]: got rv=%b data=%h rc=%0d wc=%0d perr=%b, expected 0 0000 0 0 0",
                         k, a_rvalid, a_rdata, a_rcnt, a_wcnt, a_perr);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_byteenable_hazard();
        test_back_to_back();
        test_protocol_error();
        test_stall_read();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
